// File: rtl/osd_digit_render.sv
// Per-scanline OSD score renderer: 3x5 BCD glyph bits gated by time-base cell strobes.
// pix_out is registered, 1 cycle after seg_on/seg_off; no backpressure (strobe driven).
module osd_digit_render #(
   parameter int NUM_CHARS      = 4,
   parameter int CELLS_PER_CHAR = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   frame_start,
   input  logic                   line_start,
   input  logic                   row_valid,
   input  logic [2:0]             row,
   input  logic                   seg_on,
   input  logic                   seg_off,
   input  logic [4*NUM_CHARS-1:0] digits,
   output logic                   pix_out
);

   localparam int COL_W = (CELLS_PER_CHAR > 1) ? $clog2(CELLS_PER_CHAR) : 1;
   localparam int CHR_W = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(CELLS_PER_CHAR - 1);
   localparam logic [CHR_W-1:0] CHR_LAST = CHR_W'(NUM_CHARS - 1);

   typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

   state_t                 state_q, state_d;
   logic [COL_W-1:0]       col_q, col_d;
   logic [CHR_W-1:0]       chr_q, chr_d;
   logic [2:0]             row_q, row_d;
   logic [4*NUM_CHARS-1:0] digits_q, digits_d;
   logic                   pix_q, pix_d;
   logic [3:0]             cur_digit;
   logic [2:0]             glyph_bits;
   logic                   cell_bit;

   // Glyph rows packed top to bottom; within a row the MSB is column 0.
   function automatic logic [2:0] glyph_row(input logic [3:0] d, input logic [2:0] r);
      logic [14:0] g;
      logic [2:0]  res;
      case (d)
         4'd0:    g = 15'b111_101_101_101_111;
         4'd1:    g = 15'b001_001_001_001_001;
         4'd2:    g = 15'b111_001_111_100_111;
         4'd3:    g = 15'b111_001_111_001_111;
         4'd4:    g = 15'b101_101_111_001_001;
         4'd5:    g = 15'b111_100_111_001_111;
         4'd6:    g = 15'b111_100_111_101_111;
         4'd7:    g = 15'b111_001_001_001_001;
         4'd8:    g = 15'b111_101_111_101_111;
         4'd9:    g = 15'b111_101_111_001_111;
         default: g = '0;
      endcase
      case (r)
         3'd0:    res = g[14:12];
         3'd1:    res = g[11:9];
         3'd2:    res = g[8:6];
         3'd3:    res = g[5:3];
         3'd4:    res = g[2:0];
         default: res = '0;
      endcase
      return res;
   endfunction

   always_comb begin
      cur_digit  = digits_q[4*int'(chr_q) +: 4];
      glyph_bits = glyph_row(cur_digit, row_q);
      cell_bit   = 1'b0;
      if (col_q < COL_W'(3)) begin
         case (col_q[1:0])
            2'd0:    cell_bit = glyph_bits[2];
            2'd1:    cell_bit = glyph_bits[1];
            default: cell_bit = glyph_bits[0];
         endcase
      end
   end

   always_comb begin
      state_d  = state_q;
      col_d    = col_q;
      chr_d    = chr_q;
      row_d    = row_q;
      pix_d    = pix_q;
      digits_d = digits_q;
      if (frame_start) begin
         digits_d = digits;
      end
      // line_start wins over any strobe arriving in the same cycle.
      if (line_start) begin
         row_d   = row;
         col_d   = '0;
         chr_d   = '0;
         pix_d   = 1'b0;
         state_d = row_valid ? ACTIVE : IDLE;
      end else begin
         case (state_q)
            ACTIVE: begin
               if (seg_off) begin
                  pix_d = 1'b0;
                  if (col_q == COL_LAST) begin
                     col_d = '0;
                     if (chr_q == CHR_LAST) begin
                        state_d = DONE;
                     end else begin
                        chr_d = chr_q + CHR_W'(1);
                     end
                  end else begin
                     col_d = col_q + COL_W'(1);
                  end
               end else if (seg_on) begin
                  pix_d = cell_bit;
               end
            end
            default: pix_d = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         col_q    <= '0;
         chr_q    <= '0;
         row_q    <= '0;
         pix_q    <= 1'b0;
         digits_q <= '0;
      end else begin
         state_q  <= state_d;
         col_q    <= col_d;
         chr_q    <= chr_d;
         row_q    <= row_d;
         pix_q    <= pix_d;
         digits_q <= digits_d;
      end
   end

   assign pix_out = pix_q;

endmodule
